parity_gen: RTL and testbench

- Parity generator for the UART transmitter datapath.
- Captures a parallel data word on a load strobe and produces a registered parity bit.
- The TX shift/frame logic appends that bit after the data bits.
- Purely combinational parity reduction feeding one output register; no FSM.

---
 rtl/parity_gen.sv | 39 +++
 tb/tb_parity_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/parity_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : parity_gen                                                     |
// | Purpose : Registered parity bit for the UART TX word; loads on load_bit. |
// |           Even parity by default, odd parity when PARITY_ODD_EN is set.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module parity_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_bit,
  input  logic [WIDTH-1:0] data,
  output logic             p_out
);

  logic w_parity;
  logic r_p_out;

`ifdef PARITY_ODD_EN
  // Inverted reduction so data plus parity always holds an odd count of ones.
  assign w_parity = ~(^data);
`else
  assign w_parity = ^data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_out <= 1'b0;
    end else if (load_bit) begin
      r_p_out <= w_parity;
    end
  end

  assign p_out = r_p_out;

endmodule
`default_nettype wire

// File: tb/tb_parity_gen.sv
`default_nettype none
// Directed bench for parity_gen: scoreboard queue of expected parity bits,
// immediate assertions at every comparison point.
module tb_parity_gen;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_bit = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             p_out;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic held_exp = 1'b0;
  logic sb_q[$];

  parity_gen #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_bit (load_bit),
    .data     (data),
    .p_out    (p_out)
  );

  always #5 clk = ~clk;

  function automatic logic model_parity(input logic [WIDTH-1:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) ones += int'(d[i]);
`ifdef PARITY_ODD_EN
    return (ones % 2) == 0;
`else
    return (ones % 2) == 1;
`endif
  endfunction

  task automatic check(input string tag, input logic expected);
    n_checks++;
    assert (p_out === expected) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, p_out, expected);
    end
  endtask

  // Drive one loaded word at the falling edge, then compare one edge later.
  task automatic do_load(input string tag, input logic [WIDTH-1:0] d);
    logic e;
    @(negedge clk);
    data     = d;
    load_bit = 1'b1;
    sb_q.push_back(model_parity(d));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      held_exp = e;
      check(tag, e);
    end
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    load_bit = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset between edges with a load pending.
    @(posedge clk);
    #3;
    rst      = 1'b1;
    load_bit = 1'b1;
    data     = 8'hFF;
    #1;
    check("reset_async", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", 1'b0);
    end
    @(negedge clk);
    load_bit = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 1'b0);
    held_exp = 1'b0;

    // Basic load, then hold for ten cycles.
    do_load("load_e9", 8'b1110_1001);
    idle_cycles(10);
    check("hold_10_cycles", held_exp);

    // Data changes while not loading have no effect.
    @(negedge clk);
    data = 8'h00;
    @(posedge clk);
    #1;
    check("hold_data_00", held_exp);
    @(negedge clk);
    data = 8'h01;
    @(posedge clk);
    #1;
    check("hold_data_01", held_exp);

    // Back-to-back loads.
    do_load("b2b_00", 8'h00);
    do_load("b2b_01", 8'h01);
    do_load("b2b_03", 8'h03);
    do_load("b2b_07", 8'h07);
    idle_cycles(1);
    check("b2b_hold", held_exp);

    // Reset mid-operation discards the held parity.
    do_load("mid_load_01", 8'h01);
    @(negedge clk);
    load_bit = 1'b0;
    rst      = 1'b1;
    #1;
    check("mid_reset_async", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_reset_held", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_reset_after_release", 1'b0);
    do_load("post_reset_80", 8'h80);
    do_load("post_reset_00", 8'h00);

    // Random back-to-back loads.
    for (int i = 0; i < 12; i++) begin
      do_load("rand_load", WIDTH'($urandom_range(0, 255)));
    end
    idle_cycles(2);
    check("rand_hold", held_exp);

    // Reset while load_bit is high: reset wins.
    do_load("pre_rst_ff_fe", 8'hFE);
    @(negedge clk);
    load_bit = 1'b1;
    data     = 8'h01;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("reset_vs_load", 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    load_bit = 1'b0;

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
